// File: rtl/tri_edge_vec.sv
// rtl/tri_edge_vec.sv - two-stage triangle edge-vector pipeline with optional area/cull (TRI_EDGE_VEC_CROSS_EN)
module tri_edge_vec #(
    parameter int MAX_BIT_WIDTH = 6
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic                            valid_in,
    output logic                            ready_in,
    input  logic [MAX_BIT_WIDTH-1:0]        point_ax,
    input  logic [MAX_BIT_WIDTH-1:0]        point_ay,
    input  logic [MAX_BIT_WIDTH-1:0]        point_bx,
    input  logic [MAX_BIT_WIDTH-1:0]        point_by,
    input  logic [MAX_BIT_WIDTH-1:0]        point_cx,
    input  logic [MAX_BIT_WIDTH-1:0]        point_cy,
    output logic                            valid_out,
    input  logic                            ready_out,
    output logic signed [MAX_BIT_WIDTH:0]   vec_ab_out_x,
    output logic signed [MAX_BIT_WIDTH:0]   vec_ab_out_y,
    output logic signed [MAX_BIT_WIDTH:0]   vec_bc_out_x,
    output logic signed [MAX_BIT_WIDTH:0]   vec_bc_out_y,
    output logic signed [MAX_BIT_WIDTH:0]   vec_ca_out_x,
    output logic signed [MAX_BIT_WIDTH:0]   vec_ca_out_y,
    output logic signed [2*MAX_BIT_WIDTH+2:0] area_out,
    output logic                            cull_out
);
    localparam int W  = MAX_BIT_WIDTH;
    localparam int VW = W + 1;
    localparam int AW = 2 * W + 3;

    function automatic logic signed [VW-1:0] sub_zx(input logic [W-1:0] a, input logic [W-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_load, s2_load;

    logic signed [VW-1:0] s1_ab_x_q, s1_ab_y_q, s1_bc_x_q, s1_bc_y_q, s1_ca_x_q, s1_ca_y_q;
    logic signed [AW-1:0] area_d;
    logic                 cull_d;

    assign s2_load  = s1_valid_q && (!s2_valid_q || ready_out);
    assign s1_load  = valid_in && ready_in;
    assign ready_in = !s1_valid_q || s2_load;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (s1_load)
            s1_valid_d = 1'b1;
        else if (s2_load)
            s1_valid_d = 1'b0;
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        if (s2_load)
            s2_valid_d = 1'b1;
        else if (ready_out)
            s2_valid_d = 1'b0;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_ab_x_q <= '0;
            s1_ab_y_q <= '0;
            s1_bc_x_q <= '0;
            s1_bc_y_q <= '0;
            s1_ca_x_q <= '0;
            s1_ca_y_q <= '0;
        end else if (s1_load) begin
            s1_ab_x_q <= sub_zx(point_bx, point_ax);
            s1_ab_y_q <= sub_zx(point_by, point_ay);
            s1_bc_x_q <= sub_zx(point_cx, point_bx);
            s1_bc_y_q <= sub_zx(point_cy, point_by);
            s1_ca_x_q <= sub_zx(point_ax, point_cx);
            s1_ca_y_q <= sub_zx(point_ay, point_cy);
        end
    end

`ifdef TRI_EDGE_VEC_CROSS_EN
    logic signed [VW-1:0] s1_ac_x_q, s1_ac_y_q;
    logic signed [AW-1:0] ab_x_ext, ab_y_ext, ac_x_ext, ac_y_ext;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_ac_x_q <= '0;
            s1_ac_y_q <= '0;
        end else if (s1_load) begin
            s1_ac_x_q <= sub_zx(point_cx, point_ax);
            s1_ac_y_q <= sub_zx(point_cy, point_ay);
        end
    end

    // Sign-extend before multiplying so the products are exact in AW bits.
    assign ab_x_ext = {{(AW-VW){s1_ab_x_q[VW-1]}}, s1_ab_x_q};
    assign ab_y_ext = {{(AW-VW){s1_ab_y_q[VW-1]}}, s1_ab_y_q};
    assign ac_x_ext = {{(AW-VW){s1_ac_x_q[VW-1]}}, s1_ac_x_q};
    assign ac_y_ext = {{(AW-VW){s1_ac_y_q[VW-1]}}, s1_ac_y_q};

    always_comb begin
        area_d = (ab_x_ext * ac_y_ext) - (ab_y_ext * ac_x_ext);
        cull_d = (area_d[AW-1] == 1'b1) || (area_d == '0);
    end
`else
    always_comb begin
        area_d = '0;
        cull_d = 1'b0;
    end
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vec_ab_out_x <= '0;
            vec_ab_out_y <= '0;
            vec_bc_out_x <= '0;
            vec_bc_out_y <= '0;
            vec_ca_out_x <= '0;
            vec_ca_out_y <= '0;
            area_out     <= '0;
            cull_out     <= 1'b0;
        end else if (s2_load) begin
            vec_ab_out_x <= s1_ab_x_q;
            vec_ab_out_y <= s1_ab_y_q;
            vec_bc_out_x <= s1_bc_x_q;
            vec_bc_out_y <= s1_bc_y_q;
            vec_ca_out_x <= s1_ca_x_q;
            vec_ca_out_y <= s1_ca_y_q;
            area_out     <= area_d;
            cull_out     <= cull_d;
        end
    end

    assign valid_out = s2_valid_q;
endmodule

// File: tb/tb_tri_edge_vec.sv
// tb/tb_tri_edge_vec.sv - directed table-driven bench for tri_edge_vec
module tb_tri_edge_vec;
    localparam int W = 6;
`ifdef TRI_EDGE_VEC_CROSS_EN
    localparam bit CROSS = 1'b1;
`else
    localparam bit CROSS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_in = 1'b0, ready_in, valid_out, ready_out = 1'b0, cull_out;
    logic [W-1:0] ax = '0, ay = '0, bx = '0, by = '0, cx = '0, cy = '0;
    logic signed [W:0] abx_o, aby_o, bcx_o, bcy_o, cax_o, cay_o;
    logic signed [2*W+2:0] area_o;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tri_edge_vec #(.MAX_BIT_WIDTH(W)) dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .valid_in(valid_in), .ready_in(ready_in),
        .point_ax(ax), .point_ay(ay), .point_bx(bx), .point_by(by),
        .point_cx(cx), .point_cy(cy),
        .valid_out(valid_out), .ready_out(ready_out),
        .vec_ab_out_x(abx_o), .vec_ab_out_y(aby_o),
        .vec_bc_out_x(bcx_o), .vec_bc_out_y(bcy_o),
        .vec_ca_out_x(cax_o), .vec_ca_out_y(cay_o),
        .area_out(area_o), .cull_out(cull_out)
    );

    typedef struct {
        logic [W-1:0] ax, ay, bx, by, cx, cy;
        int abx, aby, bcx, bcy, cax, cay, area;
        bit cull;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive_tri(input logic [W-1:0] a_x, a_y, b_x, b_y, c_x, c_y);
        ax = a_x; ay = a_y; bx = b_x; by = b_y; cx = c_x; cy = c_y;
    endtask

    task automatic chk_vectors(input string name, input vec_t v);
        chk({name, " ab_x"}, int'(abx_o), v.abx);
        chk({name, " ab_y"}, int'(aby_o), v.aby);
        chk({name, " bc_x"}, int'(bcx_o), v.bcx);
        chk({name, " bc_y"}, int'(bcy_o), v.bcy);
        chk({name, " ca_x"}, int'(cax_o), v.cax);
        chk({name, " ca_y"}, int'(cay_o), v.cay);
        chk({name, " area"}, int'(area_o), CROSS ? v.area : 0);
        chk({name, " cull"}, int'(cull_out), CROSS ? int'(v.cull) : 0);
    endtask

    vec_t tbl[5];
    int recv[$];
    int sent;

    initial begin
        tbl[0] = '{ax:0,  ay:0,  bx:10, by:30, cx:20, cy:5,
                   abx:10,  aby:30, bcx:10, bcy:-25, cax:-20, cay:-5, area:-550, cull:1};
        tbl[1] = '{ax:0,  ay:0,  bx:20, by:5,  cx:10, cy:30,
                   abx:20,  aby:5,  bcx:-10, bcy:25, cax:-10, cay:-30, area:550, cull:0};
        tbl[2] = '{ax:63, ay:0,  bx:0,  by:63, cx:0,  cy:0,
                   abx:-63, aby:63, bcx:0, bcy:-63, cax:63, cay:0, area:3969, cull:0};
        tbl[3] = '{ax:5,  ay:5,  bx:5,  by:5,  cx:5,  cy:5,
                   abx:0, aby:0, bcx:0, bcy:0, cax:0, cay:0, area:0, cull:1};
        tbl[4] = '{ax:0,  ay:63, bx:63, by:0,  cx:63, cy:63,
                   abx:63, aby:-63, bcx:0, bcy:63, cax:-63, cay:0, area:3969, cull:0};

        #12;
        chk("reset valid_out", int'(valid_out), 0);
        chk("reset ab_x", int'(abx_o), 0);
        chk("reset area", int'(area_o), 0);
        chk("reset cull", int'(cull_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_in after reset", int'(ready_in), 1);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_tri(tbl[i].ax, tbl[i].ay, tbl[i].bx, tbl[i].by, tbl[i].cx, tbl[i].cy);
            valid_in = 1'b1;
            ready_out = 1'b1;
            #1 chk($sformatf("vec%0d ready_in", i), int'(ready_in), 1);
            @(posedge clk); #1;
            valid_in = 1'b0;
            chk($sformatf("vec%0d valid_out early", i), int'(valid_out), 0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d valid_out", i), int'(valid_out), 1);
            chk_vectors($sformatf("vec%0d", i), tbl[i]);
        end
        @(posedge clk); #1;
        chk("drained valid_out", int'(valid_out), 0);

        // Backpressure: four triangles with AB_x = 1..4, ready_out released at cycle 5.
        sent = 0;
        recv.delete();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            valid_in = (sent < 4);
            drive_tri(6'd0, 6'd0, 6'(sent + 1), 6'd0, 6'd0, 6'd0);
            ready_out = (c >= 5);
            #1;
            if (c == 3) begin
                chk("bp accepts before stall", sent, 2);
                chk("bp ready_in low", int'(ready_in), 0);
                chk("bp valid_out held", int'(valid_out), 1);
                chk("bp first held", int'(abx_o), 1);
            end
            if (c == 4)
                chk("bp first stable", int'(abx_o), 1);
            if (valid_out && ready_out)
                recv.push_back(int'(abx_o));
            if (valid_in && ready_in)
                sent++;
        end
        valid_in = 1'b0;
        chk("bp received count", recv.size(), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("bp order %0d", k), (k < recv.size()) ? recv[k] : -1, k + 1);

        // Reset mid-stream with both stages full.
        @(negedge clk);
        ready_out = 1'b0;
        valid_in = 1'b1;
        drive_tri(tbl[0].ax, tbl[0].ay, tbl[0].bx, tbl[0].by, tbl[0].cx, tbl[0].cy);
        @(negedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        #1 chk("pre-reset valid_out", int'(valid_out), 1);
        chk("pre-reset ready_in", int'(ready_in), 0);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset valid_out", int'(valid_out), 0);
        chk("async reset ab_y", int'(aby_o), 0);
        chk("async reset area", int'(area_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ready_out = 1'b1;
        valid_in = 1'b1;
        drive_tri(tbl[1].ax, tbl[1].ay, tbl[1].bx, tbl[1].by, tbl[1].cx, tbl[1].cy);
        #1 chk("post-reset ready_in", int'(ready_in), 1);
        @(posedge clk); #1;
        valid_in = 1'b0;
        chk("post-reset valid_out early", int'(valid_out), 0);
        @(posedge clk); #1;
        chk("post-reset valid_out", int'(valid_out), 1);
        chk_vectors("post-reset", tbl[1]);
        @(posedge clk); #1;
        chk("post-reset single output", int'(valid_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tri_edge_vec.md
# tri_edge_vec

Pipelined, parametrised successor to the point-to-vector helper. Accepts one triangle (three unsigned screen-space vertices) per cycle over a valid/ready handshake and produces the three signed edge vectors AB, BC, CA. Optionally computes the signed doubled area (AB × AC) and a backface/degenerate cull flag. Sits between vertex projection and the rasteriser setup stage in the fp-3D pipeline.

## Interface
- MAX_BIT_WIDTH, 6, unsigned vertex coordinate width W; vectors are W+1 signed, area is 2W+3 signed
- clk_in  input  1  system clock, all state on rising edge
- rst_n_in  input  1  reset, asynchronous and active-low
- valid_in  input  1  triangle on vertex inputs is valid
- ready_in  output  1  block can accept a triangle this cycle
- point_ax, point_ay, point_bx, point_by, point_cx, point_cy  input  W each  unsigned vertex coordinates
- valid_out  output  1  result outputs valid
- ready_out  input  1  downstream accepts result this cycle
- vec_ab_out_x/_y, vec_bc_out_x/_y, vec_ca_out_x/_y  output  W+1 each  signed edge vectors (B−A, C−B, A−C)
- area_out  output  2W+3  signed AB_x·AC_y − AB_y·AC_x
- cull_out  output  1  area_out ≤ 0 (clockwise or degenerate)

## Operation
- Two register stages, S1 and S2, each with its own valid bit.
- S1 captures: the three edge vectors, zero-extending operands to W+1 before subtraction. It also captures AC = C−A for internal use.
- S2 captures: the S1 edge vectors, area and cull. S2 registers drive the outputs directly.
- Stage advance rules:
  - S2 loads when S1 valid and (S2 empty or ready_out).
  - S1 loads when valid_in and ready_in.
  - ready_in = !S1_valid || S2 loads this cycle.
- Transfer at the input occurs when valid_in && ready_in. Transfer at the output occurs when valid_out && ready_out.
- Stall: while valid_out && !ready_out, all S2 outputs hold stable. Once S1 also fills, ready_in deasserts and S1 holds.
- Simultaneous accept and drain in the same cycle gives full throughput, one triangle per cycle.
- No arithmetic overflow is possible: W+1 bits exactly covers ±(2^W−1), and 2W+3 bits covers the full cross-product range.
- Reset mid-operation: both valid bits clear immediately and all in-flight triangles are dropped.
- Reset values: valid_out 0, all vector outputs 0, area_out 0, cull_out 0. ready_in is 1 once reset is released.
- Data registers load only on stage advance. No combinational path runs from valid_in to valid_out.

## Timing
- Latency: 2 cycles from the input transfer edge to valid_out, with no backpressure.
- ready_in depends combinationally on ready_out, a single gate path.
- The multiply is a single cycle in S2. The build target meets this for W ≤ 12.
- Throughput is 1 per cycle sustained. Sustained ready_out low fills both stages in 2 cycles.

## Configuration
- TRI_EDGE_VEC_CROSS_EN
  - Defined: S2 computes area_out and cull_out as above.
  - Undefined: no multipliers are instantiated, and area_out and cull_out are tied to 0.
- Pipeline depth, handshake and latency are identical with and without the macro.

## Test plan
- Basic triangle, W=6, A=(0,0), B=(10,30), C=(20,5):
  - after 2 cycles, AB=(10,30), BC=(10,−25), CA=(−20,−5)
  - area −550, cull 1
- Counter-clockwise triangle, A=(0,0), B=(20,5), C=(10,30): area +550, cull 0.
- Extremes, A=(63,0), B=(0,63), C=(0,0): AB=(−63,63), BC=(0,−63), CA=(63,0), area 3969, cull 0, no wrap.
- Degenerate triangle, A=B=C=(5,5): all vectors 0, area 0, cull 1.
- Backpressure sequence:
  - send 4 back-to-back triangles with ready_out held low
  - ready_in drops after 2 accepts and outputs hold the first triangle
  - release ready_out: all 4 emerge in order with no loss or duplication
- Reset mid-stream:
  - assert rst_n_in low with both stages valid
  - valid_out drops asynchronously and all outputs go to 0
  - after release, a fresh triangle appears 2 cycles after acceptance
- Repeat the first two scenarios with TRI_EDGE_VEC_CROSS_EN undefined: vectors unchanged, area_out=0, cull_out=0.
